// File: rtl/pulse_burst_pkg.sv
// Shared types and constants for the pulse burst generator.
package pulse_burst_pkg;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned PH_MIN = 1;
  localparam int unsigned PH_MAX = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  // Phase counters hold cycles-left-minus-one, so a 16-cycle phase loads as 15.
  function automatic logic [CNT_W-1:0] phase_init(input int unsigned cyc);
    return CNT_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/pulse_burst_gen_dcnt4.sv
// 4-bit loadable down-counter that saturates at zero, with a registered zero flag.
module dcnt4
  import pulse_burst_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] count_n;

  always_comb begin
    count_n = count;
    if (load) begin
      count_n = load_val;
    end else if (dec && (count != '0)) begin
      count_n = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      zero  <= 1'b1;
    end else begin
      count <= count_n;
      zero  <= (count_n == '0);
    end
  end

endmodule

// File: rtl/pulse_burst_gen.sv
// Emits a burst of N fixed-shape pulses on po after a load handshake.
// Optional end-of-burst strobe 'done' is built only when PULSE_BURST_DONE_EN is defined.
module pulse_burst_gen
  import pulse_burst_pkg::*;
#(
  parameter int unsigned HI_CYC = 1,
  parameter int unsigned LO_CYC = 1
) (
  input  logic             syclk,
  input  logic             srst,
  input  logic             ld_valid,
  input  logic [CNT_W-1:0] ld_count,
  output logic             ld_ready,
  output logic             po,
  output logic             busy,
  output logic [CNT_W-1:0] remain
`ifdef PULSE_BURST_DONE_EN
  ,
  output logic             done
`endif
);

  if ((HI_CYC < PH_MIN) || (HI_CYC > PH_MAX)) begin : g_bad_hi
    $error("pulse_burst_gen: HI_CYC must be within 1..16");
  end
  if ((LO_CYC < PH_MIN) || (LO_CYC > PH_MAX)) begin : g_bad_lo
    $error("pulse_burst_gen: LO_CYC must be within 1..16");
  end

  localparam logic [CNT_W-1:0] HI_INIT = phase_init(HI_CYC);
  localparam logic [CNT_W-1:0] LO_INIT = phase_init(LO_CYC);

  state_e           state, state_n;
  logic             rem_load, rem_dec, rem_zero;
  logic [CNT_W-1:0] rem_val;
  logic             ph_load, ph_dec, ph_zero;
  logic [CNT_W-1:0] ph_val, ph_count;

  dcnt4 u_remain (
    .clk      (syclk),
    .rst_n    (srst),
    .load     (rem_load),
    .load_val (rem_val),
    .dec      (rem_dec),
    .count    (remain),
    .zero     (rem_zero)
  );

  dcnt4 u_phase (
    .clk      (syclk),
    .rst_n    (srst),
    .load     (ph_load),
    .load_val (ph_val),
    .dec      (ph_dec),
    .count    (ph_count),
    .zero     (ph_zero)
  );

  always_ff @(posedge syclk) begin
    if (!srst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    rem_load = 1'b0;
    rem_val  = ld_count - CNT_W'(1);
    rem_dec  = 1'b0;
    ph_load  = 1'b0;
    ph_val   = HI_INIT;
    ph_dec   = 1'b0;
    case (state)
      IDLE: begin
        if (ld_valid && (ld_count != '0)) begin
          state_n  = HIGH;
          rem_load = 1'b1;
          ph_load  = 1'b1;
          ph_val   = HI_INIT;
        end
      end
      HIGH: begin
        if (ph_zero) begin
          state_n = LOW;
          ph_load = 1'b1;
          ph_val  = LO_INIT;
        end else begin
          ph_dec = 1'b1;
        end
      end
      LOW: begin
        // The last LOW phase runs to completion so bursts stay separated.
        if (ph_zero) begin
          if (!rem_zero) begin
            state_n = HIGH;
            rem_dec = 1'b1;
            ph_load = 1'b1;
            ph_val  = HI_INIT;
          end else begin
            state_n = IDLE;
          end
        end else begin
          ph_dec = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they align with the state flop.
  always_ff @(posedge syclk) begin
    if (!srst) begin
      po       <= 1'b0;
      busy     <= 1'b0;
      ld_ready <= 1'b1;
    end else begin
      po       <= (state_n == HIGH);
      busy     <= (state_n != IDLE);
      ld_ready <= (state_n == IDLE);
    end
  end

`ifdef PULSE_BURST_DONE_EN
  logic done_n;

  always_comb begin
    done_n = ((state == IDLE) && ld_valid && (ld_count == '0)) ||
             ((state == LOW) && ph_zero && rem_zero);
  end

  always_ff @(posedge syclk) begin
    if (!srst) begin
      done <= 1'b0;
    end else begin
      done <= done_n;
    end
  end
`endif

endmodule

// File: tb/tb_pulse_burst_gen.sv
// Bench for pulse_burst_gen: two instances (HI=1/LO=1 and HI=2/LO=3) share one stimulus stream.
// Checks 'done' only when PULSE_BURST_DONE_EN is defined.
module tb_pulse_burst_gen;

  logic       syclk = 1'b0;
  logic       srst;
  logic       ld_valid;
  logic [3:0] ld_count;

  logic       ready_a, po_a, busy_a, done_a;
  logic [3:0] remain_a;
  logic       ready_b, po_b, busy_b, done_b;
  logic [3:0] remain_b;

  always #5 syclk = ~syclk;

  pulse_burst_gen #(.HI_CYC(1), .LO_CYC(1)) dut_a (
    .syclk    (syclk),
    .srst     (srst),
    .ld_valid (ld_valid),
    .ld_count (ld_count),
    .ld_ready (ready_a),
    .po       (po_a),
    .busy     (busy_a),
    .remain   (remain_a)
`ifdef PULSE_BURST_DONE_EN
    ,
    .done     (done_a)
`endif
  );

  pulse_burst_gen #(.HI_CYC(2), .LO_CYC(3)) dut_b (
    .syclk    (syclk),
    .srst     (srst),
    .ld_valid (ld_valid),
    .ld_count (ld_count),
    .ld_ready (ready_b),
    .po       (po_b),
    .busy     (busy_b),
    .remain   (remain_b)
`ifdef PULSE_BURST_DONE_EN
    ,
    .done     (done_b)
`endif
  );

`ifndef PULSE_BURST_DONE_EN
  assign done_a = 1'b0;
  assign done_b = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: a burst is just a start time and a length; outputs follow from elapsed cycles.
  typedef struct {
    bit active;
    int n;
    int k;
    bit done;
  } mdl_t;

  mdl_t m [2];
  int   hc [2] = '{1, 2};
  int   lc [2] = '{1, 3};
  bit   mvalid = 1'b0;

  typedef struct {
    bit r;
    bit v;
    int c;
    bit po;
    bit busy;
    bit rdy;
    int rem;
    bit dn;
  } vec_t;

  vec_t vt [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void mstep(input int i, input bit r, input bit v, input int c);
    if (!r) begin
      m[i].active = 1'b0;
      m[i].done   = 1'b0;
      m[i].n      = 0;
      m[i].k      = 0;
    end else if (m[i].active) begin
      m[i].k++;
      m[i].done = 1'b0;
      if (m[i].k == m[i].n * (hc[i] + lc[i])) begin
        m[i].active = 1'b0;
        m[i].done   = 1'b1;
      end
    end else begin
      m[i].done = 1'b0;
      if (v) begin
        if (c > 0) begin
          m[i].active = 1'b1;
          m[i].n      = c;
          m[i].k      = 0;
        end else begin
          m[i].done = 1'b1;
        end
      end
    end
  endfunction

  task automatic cmp_model(input int i, input logic p, input logic b, input logic rd,
                           input logic [3:0] rem, input logic dn);
    int per;
    int e_po;
    int e_rem;
    per   = hc[i] + lc[i];
    e_po  = (m[i].active && ((m[i].k % per) < hc[i])) ? 1 : 0;
    e_rem = m[i].active ? (m[i].n - 1 - m[i].k / per) : 0;
    chk($sformatf("model%0d_po", i), 32'(p), 32'(e_po));
    chk($sformatf("model%0d_busy", i), 32'(b), 32'(m[i].active));
    chk($sformatf("model%0d_ready", i), 32'(rd), 32'(!m[i].active));
    chk($sformatf("model%0d_remain", i), 32'(rem), 32'(e_rem));
`ifdef PULSE_BURST_DONE_EN
    chk($sformatf("model%0d_done", i), 32'(dn), 32'(m[i].done));
`else
    if (dn !== 1'b0) chk($sformatf("model%0d_done_tie", i), 32'(dn), 32'd0);
`endif
  endtask

  task automatic cycle(input bit r, input bit v, input int c);
    srst     = r;
    ld_valid = v;
    ld_count = 4'(c);
    @(posedge syclk);
    mstep(0, r, v, c);
    mstep(1, r, v, c);
    if (!r) mvalid = 1'b1;
    #1;
    if (mvalid) begin
      cmp_model(0, po_a, busy_a, ready_a, remain_a, done_a);
      cmp_model(1, po_b, busy_b, ready_b, remain_b, done_b);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(ready_a && ready_b) && (n < 200)) begin
      cycle(1'b1, 1'b0, 0);
      n++;
    end
    if (!(ready_a && ready_b)) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  // Counts dut_a pulses and busy cycles from the current cycle until it is ready again.
  task automatic count_a(input bit hv, input int hcnt, output int rises, output int busyc,
                         output bit wrap);
    bit prev;
    bit seen0;
    rises = po_a ? 1 : 0;
    busyc = busy_a ? 1 : 0;
    prev  = po_a;
    seen0 = (remain_a == 4'd0);
    wrap  = 1'b0;
    for (int i = 0; (i < 80) && !ready_a; i++) begin
      cycle(1'b1, hv, hcnt);
      if (po_a && !prev) rises++;
      prev = po_a;
      if (busy_a) busyc++;
      if (seen0 && (remain_a == 4'd15)) wrap = 1'b1;
      if (remain_a == 4'd0) seen0 = 1'b1;
    end
    if (!ready_a) chk("burst_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int        rises;
    int        busyc;
    bit        wrap;
    logic [9:0] pat;

    srst     = 1'b0;
    ld_valid = 1'b0;
    ld_count = 4'd0;

    // Reset, including a load presented while reset is asserted.
    cycle(1'b0, 1'b0, 0);
    cycle(1'b0, 1'b1, 5);
    chk("rst_po", 32'(po_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_ready", 32'(ready_a), 32'd1);
    chk("rst_remain", 32'(remain_a), 32'd0);
`ifdef PULSE_BURST_DONE_EN
    chk("rst_done", 32'(done_a), 32'd0);
`endif

    // Three-pulse burst at HI=LO=1, expected outputs written out cycle by cycle.
    vt[0] = '{r:1, v:1, c:3, po:1, busy:1, rdy:0, rem:2, dn:0};
    vt[1] = '{r:1, v:0, c:0, po:0, busy:1, rdy:0, rem:2, dn:0};
    vt[2] = '{r:1, v:0, c:0, po:1, busy:1, rdy:0, rem:1, dn:0};
    vt[3] = '{r:1, v:0, c:0, po:0, busy:1, rdy:0, rem:1, dn:0};
    vt[4] = '{r:1, v:0, c:0, po:1, busy:1, rdy:0, rem:0, dn:0};
    vt[5] = '{r:1, v:0, c:0, po:0, busy:1, rdy:0, rem:0, dn:0};
    vt[6] = '{r:1, v:0, c:0, po:0, busy:0, rdy:1, rem:0, dn:1};
    for (int i = 0; i < 7; i++) begin
      cycle(vt[i].r, vt[i].v, vt[i].c);
      chk($sformatf("vec%0d_po", i), 32'(po_a), 32'(vt[i].po));
      chk($sformatf("vec%0d_busy", i), 32'(busy_a), 32'(vt[i].busy));
      chk($sformatf("vec%0d_ready", i), 32'(ready_a), 32'(vt[i].rdy));
      chk($sformatf("vec%0d_remain", i), 32'(remain_a), 32'(vt[i].rem));
`ifdef PULSE_BURST_DONE_EN
      chk($sformatf("vec%0d_done", i), 32'(done_a), 32'(vt[i].dn));
`endif
    end
    wait_idle();

    // Two pulses at HI=2, LO=3 on dut_b.
    pat = 10'b1100011000;
    cycle(1'b1, 1'b1, 2);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("b_po_%0d", k), 32'(po_b), 32'(pat[9-k]));
      chk($sformatf("b_remain_%0d", k), 32'(remain_b), (k < 5) ? 32'd1 : 32'd0);
      chk($sformatf("b_busy_%0d", k), 32'(busy_b), 32'd1);
      cycle(1'b1, 1'b0, 0);
    end
    chk("b_ready_after", 32'(ready_b), 32'd1);
    wait_idle();

    // Zero-length load.
    cycle(1'b1, 1'b1, 0);
    chk("zero_po", 32'(po_a), 32'd0);
    chk("zero_busy", 32'(busy_b), 32'd0);
    chk("zero_ready", 32'(ready_a), 32'd1);
`ifdef PULSE_BURST_DONE_EN
    chk("zero_done", 32'(done_a), 32'd1);
`endif
    cycle(1'b1, 1'b0, 0);

    // Maximum count: 15 pulses, 30 busy cycles, no wrap.
    cycle(1'b1, 1'b1, 15);
    count_a(1'b0, 0, rises, busyc, wrap);
    chk("max_rises", 32'(rises), 32'd15);
    chk("max_busy", 32'(busyc), 32'd30);
    chk("max_wrap", 32'(wrap), 32'd0);
    wait_idle();

    // Load held valid during a burst is only taken in the first IDLE cycle.
    cycle(1'b1, 1'b1, 5);
    count_a(1'b1, 9, rises, busyc, wrap);
    chk("hold_first_rises", 32'(rises), 32'd5);
    cycle(1'b1, 1'b1, 9);
    chk("hold_accept_busy", 32'(busy_a), 32'd1);
    chk("hold_accept_remain", 32'(remain_a), 32'd8);
    count_a(1'b0, 0, rises, busyc, wrap);
    chk("hold_second_rises", 32'(rises), 32'd9);
    wait_idle();

    // Reset during the second HIGH phase of a four-pulse burst.
    cycle(1'b1, 1'b1, 4);
    cycle(1'b1, 1'b0, 0);
    cycle(1'b1, 1'b0, 0);
    chk("mid_second_high", 32'(po_a), 32'd1);
    cycle(1'b0, 1'b0, 0);
    chk("mid_rst_po", 32'(po_a), 32'd0);
    chk("mid_rst_busy", 32'(busy_a), 32'd0);
    chk("mid_rst_remain", 32'(remain_a), 32'd0);
`ifdef PULSE_BURST_DONE_EN
    chk("mid_rst_done", 32'(done_a), 32'd0);
`endif
    cycle(1'b1, 1'b1, 1);
    count_a(1'b0, 0, rises, busyc, wrap);
    chk("after_rst_rises", 32'(rises), 32'd1);
    chk("after_rst_busy", 32'(busyc), 32'd2);
    wait_idle();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) == 0),
            int'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulse_burst_gen.md
PULSE_BURST_GEN -- requirements
Module: pulse_burst_gen

Interface
REQ-001 Parameter: HI_CYC, 1, cycles po is high per pulse (legal 1..16).
REQ-002 Parameter: LO_CYC, 1, cycles po is low after each pulse (legal 1..16).
REQ-003 Port: syclk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port: srst  input  1  reset, synchronous, active-low.
REQ-005 Port: ld_valid  input  1  load request.
REQ-006 Port: ld_count  input  4  number of pulses to emit (0..15).
REQ-007 Port: ld_ready  output  1  block can accept a load.
REQ-008 Port: po  output  1  registered pulse-train output.
REQ-009 Port: busy  output  1  burst in progress.
REQ-010 Port: remain  output  4  pulses not yet started.
REQ-011 Port: done  output  1  end-of-burst strobe (present only per REQ-027).

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, HIGH, LOW.
REQ-013 ld_ready SHALL be 1 in IDLE and 0 in HIGH and LOW.
REQ-014 A load SHALL be accepted on a cycle with ld_valid=1 and ld_ready=1; ld_valid while not ready SHALL be ignored, not queued.
REQ-015 Accepted ld_count=N>0: next cycle enter HIGH, remain=N-1, busy=1, po=1 (one-cycle latency).
REQ-016 Accepted ld_count=0: SHALL stay in IDLE with po=0, busy=0, ld_ready=1; no pulse emitted.
REQ-017 HIGH SHALL last exactly HI_CYC cycles with po=1, then go to LOW.
REQ-018 LOW SHALL last exactly LO_CYC cycles with po=0; at its end: remain>0 -> HIGH and remain decrements; remain=0 -> IDLE.
REQ-019 A burst of N SHALL therefore occupy exactly N*(HI_CYC+LO_CYC) cycles with busy=1, including the final LOW phase, guaranteeing LO_CYC low cycles between back-to-back bursts.
REQ-020 po SHALL come directly from a flop; no combinational path from any input to po.
REQ-021 remain SHALL never wrap below 0; ld_count=15 SHALL produce exactly 15 pulses.
REQ-022 Phase counter SHALL be 4 bits holding cycles-left-minus-one; HI_CYC/LO_CYC=16 SHALL be loaded as 15.

Reset
REQ-023 With srst=0 at a rising edge: state=IDLE, po=0, busy=0, remain=0, phase counter=0, done=0, ld_ready=1 from the next cycle.
REQ-024 Reset mid-burst SHALL abort the burst immediately; no partial pulse SHALL continue after the reset edge.
REQ-025 A load presented in the cycle srst=0 SHALL be ignored.

Configuration
REQ-026 Macro PULSE_BURST_DONE_EN SHALL gate the done port and its logic.
REQ-027 Defined: done SHALL be 1 for exactly one cycle, the first cycle back in IDLE after a burst of N>0, and also the cycle after an accepted N=0 load; otherwise 0.
REQ-028 Not defined: done port and its flop SHALL be absent; all other behaviour identical.

Structure
REQ-029 Package pulse_burst_pkg SHALL hold the state enum (IDLE, HIGH, LOW), the 4-bit count width constant, and phase-length limits (1, 16).
REQ-030 One sub-module, dcnt4 (4-bit loadable down-counter with zero flag), SHALL be used twice: once for remain, once for the phase counter.
REQ-031 Illegal HI_CYC/LO_CYC values SHALL be rejected at elaboration.

Verification
REQ-032 HI=1, LO=1, load N=3 at cycle 0 -> po=1,0,1,0,1,0 on cycles 1..6; busy high cycles 1..6; ld_ready=1 at cycle 7; done=1 at cycle 7 (if enabled).
REQ-033 HI=2, LO=3, load N=2 -> po pattern 11000 11000 over cycles 1..10; remain 1 during the first pulse, 0 during the second.
REQ-034 Load N=0 -> po stays 0, busy stays 0, ld_ready stays 1; done=1 the next cycle (if enabled).
REQ-035 Load N=15, HI=LO=1 -> exactly 15 rising edges on po, 30 busy cycles, remain never wraps to 15 after 0.
REQ-036 Load N=5, hold ld_valid=1 with ld_count=9 during the burst -> exactly 5 pulses; a new load is accepted only in the first IDLE cycle, 9 pulses follow.
REQ-037 Load N=4, assert srst=0 during the second HIGH phase -> po=0, busy=0, remain=0 the next cycle; no done strobe; a fresh load N=1 afterwards emits exactly 1 pulse.
